gesture_swipe_detector: RTL and testbench
=========================================

Name: gesture_swipe_detector

Overview:
- Parametrised two-hand swipe-gesture recogniser and successor to the fixed 5-strip "off" gesture FSM.
- Each hand must start in the centre x-strip, sweep outward DEPTH strips (left hand leftward, right hand rightward), then sweep back to centre, all inside the lower y band.
- Adds a frame-valid strobe, per-step timeout and a pairing window between hands, and produces a single-cycle gesture pulse.
- Sits between the hand-tracking coordinate outputs and the drone command logic.

Parameters:
- MAX_X, 1023, largest valid x coordinate.
- MAX_Y, 767, largest valid y coordinate.
- ZONES, 5, number of equal vertical strips; must be odd, 3..15.
- DEPTH, 2, strips travelled outward from centre; 1..(ZONES-1)/2.
- Y_LO, 2*MAX_Y/3, a sample is in-band only when Y_LO < y <= MAX_Y.
- TIMEOUT, 1000000, clocks allowed without progress before a hand aborts; >= 1.
- PAIR_WINDOW, 500000, clocks a finished hand waits for its partner; >= 1.
- TWO_HAND, 1, 1 = both hands required; 0 = either hand alone fires.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- coord_valid  in  1  x1/y1/x2/y2 hold a new frame this cycle
- x1  in  16  left-hand x
- y1  in  16  left-hand y
- x2  in  16  right-hand x
- y2  in  16  right-hand y
- gesture_pulse  out  1  one-cycle pulse when the gesture completes
- left_phase  out  3  0 IDLE, 1 CENTER, 2 OUT, 3 IN, 4 DONE
- right_phase  out  3  same encoding as left_phase
- left_step  out  4  strips currently displaced from centre
- right_step  out  4  strips currently displaced from centre

Behaviour:
- Reset has priority: phases IDLE, steps 0, gesture_pulse 0, all counters 0.
- Strip boundaries: b_k = k*(MAX_X+1)/ZONES (integer, elaboration-time), for k = 0..ZONES. Zone k is b_k <= x < b_(k+1); lower bound inclusive, no gaps. Centre C = ZONES/2.
- Invalid sample for a hand: x > MAX_X, or y outside the band.
- Expected zone: left hand C - step, right hand C + step.
- Per-hand FSM advances only on cycles with coord_valid=1. Without coord_valid, state holds and only counters run.
  - IDLE: zone C -> CENTER, step 0.
  - CENTER: zone C stays. Zone of step 1 -> OUT, step 1. Otherwise -> IDLE.
  - OUT: same zone stays. Next outward zone -> step+1. On reaching step == DEPTH, the next valid sample at step DEPTH-1 -> IN, step DEPTH-1. Otherwise -> IDLE.
  - IN: same zone stays. Next inward zone -> step-1. Reaching zone C -> DONE, step 0. Otherwise -> IDLE.
  - DONE: ignores coordinates. Exits on pulse or on pair-window expiry, both -> IDLE.
  - Any invalid sample in CENTER/OUT/IN -> IDLE.
- Progress counter, per hand:
  - Cleared on every phase or step change and while in IDLE or DONE; otherwise increments each clock.
  - At TIMEOUT -> IDLE.
  - If the same cycle carries a valid advancing sample, the advance wins.
- Pair counter, per hand: counts clocks in DONE. At PAIR_WINDOW the hand goes to IDLE.
- Pulse generation:
  - TWO_HAND=1: the cycle after both hands are in DONE, gesture_pulse=1 for exactly one clock and both hands -> IDLE.
  - If both hands enter DONE on the same edge, the pulse follows on the next clock.
  - TWO_HAND=0: either hand entering DONE pulses on the next clock and that hand -> IDLE. Simultaneous completion gives a single pulse.
- Latency: completing sample -> phase DONE next edge -> gesture_pulse one edge later. No pulse is generated while reset is asserted.
- Reset mid-gesture aborts fully; no pulse follows.
- Counters are 32-bit and saturate, never wrap.

Test Plan:
- Defaults with TIMEOUT=100, PAIR_WINDOW=20; y1=y2=600; left x1 500,300,100,300,500; right x2 500,700,900,700,500; one valid sample per 5 clocks -> phases walk 1,2,2,3,4; exactly one gesture_pulse 1 clock after the final sample; both phases return to 0.
- Same sequence with x1=409 and x2=613 as centre samples -> accepted, because the lower bound is inclusive; x1=408 as a centre sample -> left stays IDLE, no pulse.
- Left completes, right's final sample arrives 25 clocks later (> PAIR_WINDOW) -> left returns to IDLE at 20 clocks; no pulse.
- Right hand stalls in OUT at x2=900 for 101 clocks with no new zone -> right_phase=0 at clock 100; later samples restart from IDLE.
- y1=400 mid-sweep -> left_phase 0 on that sample; reset asserted with both hands in IN -> all outputs 0 next edge and no pulse.
- TWO_HAND=0, only left hand sweeps (x2 held 0) -> one pulse; right_phase stays 0 throughout.

Source files
------------

// File: rtl/gesture_swipe_detector.sv
// Two-hand swipe recogniser: each hand walks centre strip -> DEPTH strips outward -> back to centre
// inside the lower y band; completed hands are paired (or taken singly) into a one-cycle gesture pulse.
module gesture_swipe_detector #(
  parameter int unsigned MAX_X       = 1023,
  parameter int unsigned MAX_Y       = 767,
  parameter int unsigned ZONES       = 5,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned Y_LO        = 2 * MAX_Y / 3,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned PAIR_WINDOW = 500000,
  parameter int unsigned TWO_HAND    = 1,
  localparam int unsigned COORD_W    = 16,
  localparam int unsigned PHASE_W    = 3,
  localparam int unsigned STEP_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic               gesture_pulse,
  output logic [PHASE_W-1:0] left_phase,
  output logic [PHASE_W-1:0] right_phase,
  output logic [STEP_W-1:0]  left_step,
  output logic [STEP_W-1:0]  right_step
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned DISP_W   = STEP_W + 2;
  localparam int unsigned CENTRE_Z = ZONES / 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE   = 3'd0,
    PH_CENTER = 3'd1,
    PH_OUT    = 3'd2,
    PH_IN     = 3'd3,
    PH_DONE   = 3'd4
  } phase_t;

  phase_t             phase_q [2];
  phase_t             phase_d [2];
  logic [STEP_W-1:0]  step_q  [2];
  logic [STEP_W-1:0]  step_d  [2];
  logic [CNT_W-1:0]   prog_q  [2];
  logic [CNT_W-1:0]   prog_d  [2];
  logic [CNT_W-1:0]   pair_q  [2];
  logic [CNT_W-1:0]   pair_d  [2];

  logic [COORD_W-1:0] hand_x  [2];
  logic [COORD_W-1:0] hand_y  [2];
  logic [DISP_W-1:0]  disp_c  [2];
  logic               ok_c    [2];
  logic               hold_c  [2];
  logic               fwd_c   [2];
  logic               back_c  [2];
  logic               fire_c;

  // Strip index of x: highest k whose lower boundary k*(MAX_X+1)/ZONES is <= x.
  function automatic logic [STEP_W-1:0] zone_of(input logic [COORD_W-1:0] x);
    logic [STEP_W-1:0] z;
    z = '0;
    for (int unsigned k = 1; k < ZONES; k++) begin
      if (32'(x) >= (k * (MAX_X + 1)) / ZONES) z = STEP_W'(k);
    end
    return z;
  endfunction

  assign hand_x[0] = x1;
  assign hand_x[1] = x2;
  assign hand_y[0] = y1;
  assign hand_y[1] = y2;

  // Displacement from centre in each hand's own outward direction (negative values wrap and never match).
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      ok_c[h]   = (32'(hand_x[h]) <= MAX_X) && (32'(hand_y[h]) > Y_LO) && (32'(hand_y[h]) <= MAX_Y);
      disp_c[h] = (h == 0) ? DISP_W'(CENTRE_Z) - DISP_W'(zone_of(hand_x[h]))
                           : DISP_W'(zone_of(hand_x[h])) - DISP_W'(CENTRE_Z);
      hold_c[h] = ok_c[h] && (disp_c[h] == DISP_W'(step_q[h]));
      fwd_c[h]  = ok_c[h] && (disp_c[h] == DISP_W'(step_q[h]) + DISP_W'(1));
      back_c[h] = ok_c[h] && (disp_c[h] == DISP_W'(step_q[h]) - DISP_W'(1));
    end
  end

  // Per-hand next state, progress timeout and pairing window.
  always_comb begin
    fire_c = (TWO_HAND != 0) ? (phase_q[0] == PH_DONE && phase_q[1] == PH_DONE)
                             : (phase_q[0] == PH_DONE || phase_q[1] == PH_DONE);
    for (int h = 0; h < 2; h++) begin
      phase_d[h] = phase_q[h];
      step_d[h]  = step_q[h];
      prog_d[h]  = '0;
      pair_d[h]  = '0;

      if (coord_valid) begin
        case (phase_q[h])
          PH_IDLE: begin
            if (hold_c[h]) begin
              phase_d[h] = PH_CENTER;
              step_d[h]  = '0;
            end
          end
          PH_CENTER: begin
            if (fwd_c[h]) begin
              phase_d[h] = PH_OUT;
              step_d[h]  = STEP_W'(1);
            end else if (!hold_c[h]) begin
              phase_d[h] = PH_IDLE;
              step_d[h]  = '0;
            end
          end
          PH_OUT: begin
            if (fwd_c[h] && step_q[h] < STEP_W'(DEPTH)) begin
              step_d[h] = step_q[h] + STEP_W'(1);
            end else if (back_c[h] && step_q[h] == STEP_W'(DEPTH)) begin
              phase_d[h] = (DEPTH == 1) ? PH_DONE : PH_IN;
              step_d[h]  = STEP_W'(DEPTH - 1);
            end else if (!hold_c[h]) begin
              phase_d[h] = PH_IDLE;
              step_d[h]  = '0;
            end
          end
          PH_IN: begin
            if (back_c[h]) begin
              phase_d[h] = (step_q[h] == STEP_W'(1)) ? PH_DONE : PH_IN;
              step_d[h]  = step_q[h] - STEP_W'(1);
            end else if (!hold_c[h]) begin
              phase_d[h] = PH_IDLE;
              step_d[h]  = '0;
            end
          end
          default: ;
        endcase
      end

      // An advancing sample clears the counter; only a stationary hand can time out.
      if ((phase_q[h] == PH_CENTER || phase_q[h] == PH_OUT || phase_q[h] == PH_IN) &&
          phase_d[h] == phase_q[h] && step_d[h] == step_q[h]) begin
        if (prog_q[h] >= CNT_W'(TIMEOUT - 1)) begin
          phase_d[h] = PH_IDLE;
          step_d[h]  = '0;
        end else begin
          prog_d[h] = (prog_q[h] == '1) ? prog_q[h] : prog_q[h] + CNT_W'(1);
        end
      end

      if (phase_q[h] == PH_DONE) begin
        if (fire_c || pair_q[h] >= CNT_W'(PAIR_WINDOW - 1)) begin
          phase_d[h] = PH_IDLE;
          step_d[h]  = '0;
        end else begin
          pair_d[h] = (pair_q[h] == '1) ? pair_q[h] : pair_q[h] + CNT_W'(1);
        end
      end
    end
  end

  // State, counters and the gesture pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int h = 0; h < 2; h++) begin
        phase_q[h] <= PH_IDLE;
        step_q[h]  <= '0;
        prog_q[h]  <= '0;
        pair_q[h]  <= '0;
      end
      gesture_pulse <= 1'b0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        phase_q[h] <= phase_d[h];
        step_q[h]  <= step_d[h];
        prog_q[h]  <= prog_d[h];
        pair_q[h]  <= pair_d[h];
      end
      gesture_pulse <= fire_c;
    end
  end

  assign left_phase  = phase_q[0];
  assign right_phase = phase_q[1];
  assign left_step   = step_q[0];
  assign right_step  = step_q[1];

endmodule

// File: tb/tb_gesture_swipe_detector.sv
// Bench for gesture_swipe_detector: vector table on a two-hand instance plus a single-hand instance sequence.
module tb_gesture_swipe_detector;

  logic        clock;
  logic        reset;
  logic        cv_a, cv_b;
  logic [15:0] x1_a, y1_a, x2_a, y2_a;
  logic [15:0] x1_b, y1_b, x2_b, y2_b;
  logic        pulse_a, pulse_b;
  logic [2:0]  lp_a, rp_a, lp_b, rp_b;
  logic [3:0]  ls_a, rs_a, ls_b, rs_b;

  gesture_swipe_detector #(.TIMEOUT(100), .PAIR_WINDOW(20), .TWO_HAND(1)) dut_a (
    .clock(clock), .reset(reset), .coord_valid(cv_a),
    .x1(x1_a), .y1(y1_a), .x2(x2_a), .y2(y2_a),
    .gesture_pulse(pulse_a), .left_phase(lp_a), .right_phase(rp_a),
    .left_step(ls_a), .right_step(rs_a)
  );

  gesture_swipe_detector #(.TIMEOUT(100), .PAIR_WINDOW(20), .TWO_HAND(0)) dut_b (
    .clock(clock), .reset(reset), .coord_valid(cv_b),
    .x1(x1_b), .y1(y1_b), .x2(x2_b), .y2(y2_b),
    .gesture_pulse(pulse_b), .left_phase(lp_b), .right_phase(rp_b),
    .left_step(ls_b), .right_step(rs_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit cv; int x1; int y1; int x2;
    int lp; int rp; int ls; int rs; int pl; int gap;
  } vec_t;

  typedef struct { int lp; int rp; int ls; int rs; int pl; } exp_t;

  localparam int BX [5] = '{500, 300, 100, 300, 500};
  localparam int BP [5] = '{1, 2, 2, 3, 4};
  localparam int BS [5] = '{0, 1, 2, 1, 0};

  vec_t tbl [$];
  exp_t sb  [$];
  int   passed = 0;
  int   total  = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;
  int   right_b_moved = 0;

  always @(negedge clock) begin
    if (pulse_a === 1'b1) pulses_a++;
    if (pulse_b === 1'b1) pulses_b++;
    if (rp_b !== 3'd0) right_b_moved = 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic push_exp(input int lp, input int rp, input int ls, input int rs, input int pl);
    exp_t e;
    e.lp = lp; e.rp = rp; e.ls = ls; e.rs = rs; e.pl = pl;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input bit use_b, input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", idx, 0, 1);
      return;
    end
    e = sb.pop_front();
    check(use_b ? "b_left_phase"  : "left_phase",  idx, int'(use_b ? lp_b : lp_a), e.lp);
    check(use_b ? "b_right_phase" : "right_phase", idx, int'(use_b ? rp_b : rp_a), e.rp);
    check(use_b ? "b_left_step"   : "left_step",   idx, int'(use_b ? ls_b : ls_a), e.ls);
    check(use_b ? "b_right_step"  : "right_step",  idx, int'(use_b ? rs_b : rs_a), e.rs);
    check(use_b ? "b_pulse"       : "pulse",       idx, int'(use_b ? pulse_b : pulse_a), e.pl);
  endtask

  task automatic add(input bit rst, input bit cv, input int x1, input int y1, input int x2,
                     input int lp, input int rp, input int ls, input int rs, input int pl, input int gap);
    vec_t t;
    t.rst = rst; t.cv = cv; t.x1 = x1; t.y1 = y1; t.x2 = x2;
    t.lp = lp; t.rp = rp; t.ls = ls; t.rs = rs; t.pl = pl; t.gap = gap;
    tbl.push_back(t);
  endtask

  // Both hands from centre out to DEPTH and one strip back, one sample per 5 clocks.
  task automatic sweep_in(input int cl, input int cr);
    add(0, 1, cl,  600, cr,  1, 1, 0, 0, 0, 4);
    add(0, 1, 300, 600, 700, 2, 2, 1, 1, 0, 4);
    add(0, 1, 100, 600, 900, 2, 2, 2, 2, 0, 4);
    add(0, 1, 300, 600, 700, 3, 3, 1, 1, 0, 4);
  endtask

  initial begin
    vec_t t;
    reset = 1'b1;
    cv_a = 1'b0; x1_a = '0; y1_a = 16'(600); x2_a = '0; y2_a = 16'(600);
    cv_b = 1'b0; x1_b = '0; y1_b = 16'(600); x2_b = '0; y2_b = 16'(600);

    // reset, including priority over a valid centre sample
    add(1, 0, 500, 600, 500, 0, 0, 0, 0, 0, 0);
    add(1, 1, 500, 600, 500, 0, 0, 0, 0, 0, 0);
    // full two-hand gesture
    sweep_in(500, 500);
    add(0, 1, 500, 600, 500, 4, 4, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 2);
    // inclusive lower strip boundary on centre samples
    sweep_in(409, 613);
    add(0, 1, 409, 600, 613, 4, 4, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 2);
    // x1=408 is outside the centre strip: left never starts, right expires from DONE
    add(0, 1, 408, 600, 500, 0, 1, 0, 0, 0, 4);
    add(0, 1, 300, 600, 700, 0, 2, 0, 1, 0, 4);
    add(0, 1, 100, 600, 900, 0, 2, 0, 2, 0, 4);
    add(0, 1, 300, 600, 700, 0, 3, 0, 1, 0, 4);
    add(0, 1, 408, 600, 500, 0, 4, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 4, 0, 0, 0, 20);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 2);
    // pairing window: left expires 20 clocks after DONE, right finishes 25 clocks after left
    sweep_in(500, 500);
    add(0, 1, 500, 600, 700, 4, 3, 0, 1, 0, 18);
    add(0, 0, 0,   600, 0,   4, 3, 0, 1, 0, 0);
    add(0, 0, 0,   600, 0,   0, 3, 0, 1, 0, 4);
    add(0, 1, 0,   600, 500, 0, 4, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 4, 0, 0, 0, 17);
    add(0, 0, 0,   600, 0,   0, 4, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 2);
    // right hand stalls in OUT at step 2; timeout 100 clocks after its last advance
    add(0, 1, 0, 600, 500, 0, 1, 0, 0, 0, 4);
    add(0, 1, 0, 600, 700, 0, 2, 0, 1, 0, 4);
    add(0, 1, 0, 600, 900, 0, 2, 0, 2, 0, 49);
    add(0, 1, 0, 600, 900, 0, 2, 0, 2, 0, 48);
    add(0, 1, 0, 600, 900, 0, 2, 0, 2, 0, 0);
    add(0, 1, 0, 600, 900, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 600, 900, 0, 0, 0, 0, 0, 4);
    add(0, 1, 0, 600, 500, 0, 1, 0, 0, 0, 4);
    add(0, 1, 0, 600, 0,   0, 0, 0, 0, 0, 2);
    // left sample leaves the y band mid-sweep
    add(0, 1, 500, 600, 500, 1, 1, 0, 0, 0, 4);
    add(0, 1, 300, 400, 700, 0, 2, 0, 1, 0, 4);
    add(0, 1, 0,   600, 0,   0, 0, 0, 0, 0, 2);
    // reset with both hands in IN, coincident with the completing sample
    sweep_in(500, 500);
    add(1, 1, 500, 600, 500, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   600, 0,   0, 0, 0, 0, 0, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      reset = t.rst;
      cv_a  = t.cv;
      x1_a  = 16'(t.x1);
      y1_a  = 16'(t.y1);
      x2_a  = 16'(t.x2);
      push_exp(t.lp, t.rp, t.ls, t.rs, t.pl);
      tick();
      pop_compare(1'b0, i);
      reset = 1'b0;
      cv_a  = 1'b0;
      y1_a  = 16'(600);
      for (int g = 0; g < t.gap; g++) tick();
    end

    // single-hand mode: left alone completes, right held at x=0
    for (int i = 0; i < 5; i++) begin
      cv_b = 1'b1;
      x1_b = 16'(BX[i]);
      push_exp(BP[i], 0, BS[i], 0, 0);
      tick();
      pop_compare(1'b1, 100 + i);
      cv_b = 1'b0;
      if (i < 4) for (int g = 0; g < 4; g++) tick();
    end
    push_exp(0, 0, 0, 0, 1);
    tick();
    pop_compare(1'b1, 105);
    push_exp(0, 0, 0, 0, 0);
    tick();
    pop_compare(1'b1, 106);
    for (int g = 0; g < 3; g++) tick();

    check("pulse_count_two_hand", 0, pulses_a, 2);
    check("pulse_count_one_hand", 0, pulses_b, 1);
    check("one_hand_right_moved", 0, right_b_moved, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
